c_reg_ld_arbiter: RTL and testbench
===================================

Name: c_reg_ld_arbiter

Overview:
- Round-robin arbiter and load sequencer for one shared level-sensitive (gated-latch) register of C_WIDTH bits.
- Up to C_NUM_REQ requesters each post a load or an init request.
- The block grants one requester at a time, drives the latch data, gate, gate-enable and sync-init inputs through a fixed SETUP/OPEN/HOLD sequence, then acknowledges.
- It sits between the control fabric and the latch instance, so the latch gate is never opened while D is changing.

Parameters:
- C_WIDTH, 16, width of the latch data and of each requester's data bus.
- C_NUM_REQ, 4, number of requesters (2..8).
- C_GATE_CYCLES, 2, number of cycles LD_G is held high in OPEN (1..15).
- C_HAS_INIT, 1, 1 = requesters may issue init requests (drive LD_SINIT); 0 = REQ_INIT is ignored.

Ports:
- CLK  in  1  rising-edge clock.
- SCLR  in  1  synchronous active-high reset.
- REQ  in  C_NUM_REQ  per-requester request, level, held until ACK.
- REQ_INIT  in  C_NUM_REQ  per-requester qualifier: 1 = init request, 0 = data load; sampled with REQ.
- REQ_D  in  C_NUM_REQ*C_WIDTH  concatenated requester data, requester k at bits [k*C_WIDTH +: C_WIDTH].
- ACK  out  C_NUM_REQ  one-cycle acknowledge to the granted requester.
- GNT  out  C_NUM_REQ  one-hot grant, held from SETUP through HOLD.
- BUSY  out  1  high whenever the state is not IDLE.
- LD_D  out  C_WIDTH  latch data input.
- LD_G  out  1  latch gate.
- LD_GE  out  1  latch gate enable.
- LD_SINIT  out  1  latch sync init.
- LD_Q  in  C_WIDTH  latch output readback; used only with the optional feature.
- ERR  out  1  readback mismatch pulse; used only with the optional feature.

Behaviour:
- Reset (SCLR=1 at a rising CLK edge):
  - State goes to IDLE.
  - All outputs go to 0: ACK, GNT, BUSY, LD_D, LD_G, LD_GE, LD_SINIT, ERR.
  - The round-robin pointer goes to 0, so requester 0 has the highest priority next.
  - Reset mid-sequence abandons the load with no ACK; requesters must re-present.
- States: IDLE -> SETUP -> OPEN -> HOLD -> DONE -> IDLE.
- IDLE:
  - If any REQ bit is 1, select the first set bit at or after the pointer, wrapping modulo C_NUM_REQ.
  - Register the one-hot GNT and go to SETUP next cycle.
  - Capture REQ_D of the winner into LD_D and REQ_INIT of the winner into an internal init flag.
  - With no requests, stay in IDLE.
- SETUP: one cycle.
  - LD_D is stable, LD_G=0, LD_GE=1.
  - LD_SINIT = init flag AND C_HAS_INIT.
- OPEN: LD_G=1 for exactly C_GATE_CYCLES cycles, counted by a 4-bit counter. LD_D, LD_GE and LD_SINIT are unchanged.
- HOLD: one cycle with LD_G=0. LD_D and LD_SINIT are still held, so data is held after the gate closes.
- DONE: one cycle.
  - ACK[granted]=1; LD_GE=0, LD_SINIT=0; GNT cleared.
  - The pointer moves to the granted index + 1, wrapping.
  - Next state is IDLE.
- Latency: a request seen in IDLE produces ACK at cycle 3+C_GATE_CYCLES after the sampling edge. Minimum spacing between ACKs is 4+C_GATE_CYCLES cycles.
- LD_D is updated only on the IDLE -> SETUP transition. Changes on REQ_D after grant are ignored.
- A REQ that drops before ACK is ignored: the sequence completes and ACK is still issued.
- A REQ bit that arrives while BUSY waits for IDLE.
- Requests present in the DONE cycle are arbitrated in the following IDLE cycle using the updated pointer.
- Init loads: LD_D is driven to 0. The latch takes its own init value.
- C_HAS_INIT=0: init requests are treated as data loads.
- A REQ containing X is treated as 0.

Optional Feature:
- Macro: C_REG_LD_ARB_READBACK_EN.
- Defined:
  - In DONE, compare LD_Q with the expected value: the captured data, or the init flag's expected all-zero value.
  - On mismatch, pulse ERR=1 for that cycle. ACK is still issued.
- Undefined: LD_Q is unused, ERR is tied to 0, and no comparator logic is built.

Test Plan:
- Reset then idle: SCLR=1 for 2 cycles, REQ=0 -> all outputs 0, BUSY=0.
- Single load: C_GATE_CYCLES=2, REQ=4'b0010, REQ_D[1]=16'hA5C3 -> expected response:
  - GNT=0010 one cycle after sampling.
  - LD_D=A5C3 stable from SETUP through HOLD.
  - LD_G high exactly 2 cycles.
  - ACK[1] at cycle 5.
- Round-robin: REQ=4'b1111 held -> grants in order 0,1,2,3,0, each ACK 6 cycles apart.
- Init request: REQ_INIT[2]=1, REQ[2]=1 -> LD_SINIT=1 from SETUP through HOLD, LD_D=0, ACK[2]. Repeated with C_HAS_INIT=0 -> LD_SINIT stays 0.
- Reset mid-OPEN: assert SCLR during OPEN -> next cycle LD_G=0, GNT=0, no ACK; a re-presented REQ is then granted starting from requester 0.
- Readback (macro defined): LD_Q forced to 16'h0000 while a load of 16'h1234 completes -> ERR=1 in the DONE cycle, coincident with ACK. Correct LD_Q -> ERR=0.

Source files
------------

// File: rtl/c_reg_ld_arbiter.sv
// Round-robin arbiter and SETUP/OPEN/HOLD load sequencer for one shared gated latch.
// Optional LD_Q readback check is enabled by defining C_REG_LD_ARB_READBACK_EN.
module c_reg_ld_arbiter #(
  parameter int C_WIDTH       = 16,
  parameter int C_NUM_REQ     = 4,
  parameter int C_GATE_CYCLES = 2,
  parameter int C_HAS_INIT    = 1
) (
  input  logic                         CLK,
  input  logic                         SCLR,
  input  logic [C_NUM_REQ-1:0]         REQ,
  input  logic [C_NUM_REQ-1:0]         REQ_INIT,
  input  logic [C_NUM_REQ*C_WIDTH-1:0] REQ_D,
  output logic [C_NUM_REQ-1:0]         ACK,
  output logic [C_NUM_REQ-1:0]         GNT,
  output logic                         BUSY,
  output logic [C_WIDTH-1:0]           LD_D,
  output logic                         LD_G,
  output logic                         LD_GE,
  output logic                         LD_SINIT,
  input  logic [C_WIDTH-1:0]           LD_Q,
  output logic                         ERR
);

  localparam int   PW       = (C_NUM_REQ > 2) ? $clog2(C_NUM_REQ) : 1;
  localparam logic HAS_INIT = (C_HAS_INIT != 0);

  typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, DONE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        gnt_idx_q;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        scan_idx;
  logic                 win_found;
  logic [3:0]           cnt_q;
  logic                 init_q;
  logic [C_WIDTH-1:0]   ld_d_q;
  logic [C_NUM_REQ-1:0] gnt_q;
  logic                 in_seq;

  // First requester at or after the pointer wins; X on REQ falls through as 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      scan_idx = PW'((int'(ptr_q) + i) % C_NUM_REQ);
      if (!win_found && REQ[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = SETUP;
      SETUP:   state_d = OPEN;
      OPEN:    if (cnt_q == 4'(C_GATE_CYCLES - 1)) state_d = HOLD;
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      init_q    <= 1'b0;
      ld_d_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_q     <= C_NUM_REQ'(1) << win_idx;
            gnt_idx_q <= win_idx;
            init_q    <= REQ_INIT[win_idx] & HAS_INIT;
            // Init loads present zero so the latch's own init value wins.
            ld_d_q    <= (REQ_INIT[win_idx] & HAS_INIT) ? '0
                                                        : REQ_D[win_idx*C_WIDTH +: C_WIDTH];
          end
        end
        SETUP:   cnt_q <= '0;
        OPEN:    cnt_q <= cnt_q + 4'd1;
        DONE: begin
          gnt_q <= '0;
          ptr_q <= (gnt_idx_q == PW'(C_NUM_REQ - 1)) ? '0 : gnt_idx_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_seq   = (state_q == SETUP) || (state_q == OPEN) || (state_q == HOLD);
  assign BUSY     = (state_q != IDLE);
  assign GNT      = in_seq ? gnt_q : '0;
  assign ACK      = (state_q == DONE) ? gnt_q : '0;
  assign LD_D     = ld_d_q;
  assign LD_G     = (state_q == OPEN);
  assign LD_GE    = in_seq;
  assign LD_SINIT = in_seq & init_q;

`ifdef C_REG_LD_ARB_READBACK_EN
  assign ERR = (state_q == DONE) && (LD_Q != ld_d_q);
`else
  logic unused_ld_q;
  assign unused_ld_q = ^LD_Q;
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_c_reg_ld_arbiter.sv
// Randomized self-checking bench for c_reg_ld_arbiter against a transaction-level round-robin model.
// A second instance with C_HAS_INIT=0 shares the stimulus to check that init requests act as data loads.
module tb_c_reg_ld_arbiter;
  localparam int W = 16;
  localparam int N = 4;
  localparam int G = 2;

  logic           CLK = 1'b0;
  logic           SCLR;
  logic [N-1:0]   REQ, REQ_INIT;
  logic [N*W-1:0] REQ_D;
  logic [W-1:0]   LD_Q;

  logic [N-1:0] ack, gnt;
  logic         busy, ld_g, ld_ge, ld_sinit, err;
  logic [W-1:0] ld_d;

  logic [N-1:0] ack_n, gnt_n;
  logic         busy_n, ld_g_n, ld_ge_n, ld_sinit_n, err_n;
  logic [W-1:0] ld_d_n;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int ptr_m = 0;
  int ack_cycle = 0;

  c_reg_ld_arbiter #(.C_WIDTH(W), .C_NUM_REQ(N), .C_GATE_CYCLES(G), .C_HAS_INIT(1)) dut (
    .CLK(CLK), .SCLR(SCLR), .REQ(REQ), .REQ_INIT(REQ_INIT), .REQ_D(REQ_D),
    .ACK(ack), .GNT(gnt), .BUSY(busy), .LD_D(ld_d), .LD_G(ld_g), .LD_GE(ld_ge),
    .LD_SINIT(ld_sinit), .LD_Q(LD_Q), .ERR(err)
  );

  c_reg_ld_arbiter #(.C_WIDTH(W), .C_NUM_REQ(N), .C_GATE_CYCLES(G), .C_HAS_INIT(0)) dut_noinit (
    .CLK(CLK), .SCLR(SCLR), .REQ(REQ), .REQ_INIT(REQ_INIT), .REQ_D(REQ_D),
    .ACK(ack_n), .GNT(gnt_n), .BUSY(busy_n), .LD_D(ld_d_n), .LD_G(ld_g_n), .LD_GE(ld_ge_n),
    .LD_SINIT(ld_sinit_n), .LD_Q(LD_Q), .ERR(err_n)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int pickWinner(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N] === 1'b1) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic resetDut();
    SCLR = 1'b1;
    REQ = '0;
    REQ_INIT = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset_outs", {gnt, ack, busy, ld_g, ld_ge, ld_sinit, err, ld_d}, 64'h0);
    SCLR = 1'b0;
    ptr_m = 0;
  endtask

  // Entered at a negedge with the DUT idle; leaves at the negedge of the following idle cycle.
  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] init,
                               input logic keep, input logic [N*W-1:0] data);
    int           w;
    logic [W-1:0] exp_d;
    logic         exp_init;
    logic         exp_err;
    logic         exp_g;
    logic         seq;
    logic [N-1:0] oh;
    logic [11:0]  exp_v;
    REQ = req;
    REQ_INIT = init;
    REQ_D = data;
    w = pickWinner(req, ptr_m);
    @(posedge CLK);
    @(negedge CLK);
    if (w < 0) begin
      checkOutput("idle_stays", {gnt, ack, busy, ld_g, ld_ge, ld_sinit}, 64'h0);
      return;
    end
    oh = N'(1) << w;
    exp_init = init[w];
    exp_d = exp_init ? '0 : data[w*W +: W];
    exp_err = 1'b0;
    for (int c = 1; c <= 3 + G; c++) begin
      exp_g = (c >= 2) && (c <= 1 + G);
      seq = (c <= 2 + G);
      exp_v = {seq ? oh : 4'b0, seq ? 4'b0 : oh, 1'b1, exp_g, seq, seq & exp_init};
      checkOutput($sformatf("seq_c%0d", c), {gnt, ack, busy, ld_g, ld_ge, ld_sinit}, exp_v);
      if (seq) checkOutput($sformatf("ld_d_c%0d", c), ld_d, exp_d);
      if (c == 1) begin
        checkOutput("noinit_sinit", ld_sinit_n, 64'h0);
        checkOutput("noinit_ld_d", ld_d_n, data[w*W +: W]);
        REQ_D = {$urandom, $urandom};
      end
      if (c == 2 && !keep && $urandom_range(0, 1) == 1) REQ = '0;
      if (c == 2 + G) begin
`ifdef C_REG_LD_ARB_READBACK_EN
        exp_err = ($urandom_range(0, 3) == 0);
        LD_Q = exp_err ? (exp_d ^ W'($urandom_range(1, 65535))) : exp_d;
`else
        LD_Q = W'($urandom);
`endif
      end
      if (c == 3 + G) begin
        checkOutput("err_done", err, exp_err);
        ack_cycle = cycle;
        if (!keep) REQ = '0;
      end
      if (c < 3 + G) begin
        @(posedge CLK);
        @(negedge CLK);
      end
    end
    ptr_m = (w + 1) % N;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("idle_after", {busy, ack, err}, 64'h0);
  endtask

  initial begin
    logic [N*W-1:0] d;
    int prev_ack;
    SCLR = 1'b1;
    REQ = '0;
    REQ_INIT = '0;
    REQ_D = '0;
    LD_Q = '0;
    resetDut();

    d = {$urandom, $urandom};
    d[1*W +: W] = 16'hA5C3;
    applyStimulus(4'b0010, 4'b0000, 1'b0, d);

    resetDut();
    prev_ack = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b1, {$urandom, $urandom});
      if (i > 0) checkOutput("ack_spacing", ack_cycle - prev_ack, 4 + G);
      prev_ack = ack_cycle;
    end
    REQ = '0;

    applyStimulus(4'b0100, 4'b0100, 1'b0, {$urandom, $urandom});

    REQ = 4'b1000;
    REQ_INIT = '0;
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("open_gate", {ld_g, gnt}, {1'b1, 4'b1000});
    SCLR = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("midopen_reset", {gnt, ack, busy, ld_g, ld_ge, ld_sinit, ld_d}, 64'h0);
    SCLR = 1'b0;
    REQ = '0;
    ptr_m = 0;
    applyStimulus(4'b1101, 4'b0000, 1'b0, {$urandom, $urandom});

    for (int i = 0; i < 40; i++) begin
      applyStimulus(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
